// File: rtl/reg_port_sequencer_if.sv
// rtl/reg_port_sequencer_if.sv - instruction, operand, writeback and register-file port bundle
interface reg_port_sequencer_if #(
   parameter int DW = 16,
   parameter int IW = 3
);
   logic          ins_valid;
   logic          ins_ready;
   logic [15:0]   ins;
   logic          op_valid;
   logic          op_ready;
   logic [3:0]    op_opcode;
   logic [IW-1:0] op_rd;
   logic [DW-1:0] op_a;
   logic [DW-1:0] op_b;
   logic          op_illegal;
   logic          wb_valid;
   logic [IW-1:0] wb_reg;
   logic [DW-1:0] wb_data;
   logic          rf_en;
   logic          rf_we;
   logic [3:0]    rf_sel_a;
   logic [3:0]    rf_sel_b;
   logic [3:0]    rf_sel_d;
   logic [DW-1:0] rf_data_d;
   logic [DW-1:0] rf_data_a;
   logic [DW-1:0] rf_data_b;

   modport master (
      input  ins_valid, ins, op_ready, wb_valid, wb_reg, wb_data, rf_data_a, rf_data_b,
      output ins_ready, op_valid, op_opcode, op_rd, op_a, op_b, op_illegal,
             rf_en, rf_we, rf_sel_a, rf_sel_b, rf_sel_d, rf_data_d
   );

   modport slave (
      output ins_valid, ins, op_ready, wb_valid, wb_reg, wb_data, rf_data_a, rf_data_b,
      input  ins_ready, op_valid, op_opcode, op_rd, op_a, op_b, op_illegal,
             rf_en, rf_we, rf_sel_a, rf_sel_b, rf_sel_d, rf_data_d
   );
endinterface

// File: rtl/reg_port_sequencer.sv
// rtl/reg_port_sequencer.sv - decode, register-file read issue, operand capture and writeback merge
// Optional RAW scoreboard stall enabled by defining RF_SCOREBOARD_EN.
module reg_port_sequencer #(
   parameter int          DW        = 16,
   parameter int          NREGS     = 8,
   parameter logic [15:0] NOWR_MASK = 16'hC000
) (
   input logic                 clk,
   input logic                 rst,
   reg_port_sequencer_if.master port
);
   localparam int IW = $clog2(NREGS);

   typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;
   state_t state, state_nx;

   logic [3:0]    f_op, f_rd, f_ra, f_rb;
   logic          ins_ready_c, issue, op_hs, stall;
   logic [3:0]    opcode_q;
   logic [IW-1:0] rd_q;
   logic          illegal_q;
   logic [3:0]    sel_a_q, sel_b_q;
   logic          fwd_a_q, fwd_b_q;
   logic [DW-1:0] fwd_data_q;
   logic [DW-1:0] op_a_q, op_b_q;
   logic          op_valid_q;

   assign f_op = port.ins[15:12];
   assign f_rd = port.ins[11:8];
   assign f_ra = port.ins[7:4];
   assign f_rb = port.ins[3:0];

   assign ins_ready_c = (state == IDLE) && !stall;
   assign issue       = port.ins_valid && ins_ready_c;
   assign op_hs       = (state == HOLD) && port.op_ready;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (issue) state_nx = READ;
         READ:    state_nx = HOLD;
         HOLD:    if (op_hs) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         opcode_q   <= '0;
         rd_q       <= '0;
         illegal_q  <= 1'b0;
         sel_a_q    <= '0;
         sel_b_q    <= '0;
         fwd_a_q    <= 1'b0;
         fwd_b_q    <= 1'b0;
         fwd_data_q <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         op_valid_q <= 1'b0;
      end else begin
         state <= state_nx;
         if (issue) begin
            opcode_q   <= f_op;
            rd_q       <= f_rd[IW-1:0];
            illegal_q  <= f_rd[3] | f_ra[3] | f_rb[3];
            sel_a_q    <= 4'(f_ra[IW-1:0]);
            sel_b_q    <= 4'(f_rb[IW-1:0]);
            // The file returns the pre-write value for a same-cycle write, so remember it here
            fwd_a_q    <= port.wb_valid && (port.wb_reg == f_ra[IW-1:0]);
            fwd_b_q    <= port.wb_valid && (port.wb_reg == f_rb[IW-1:0]);
            fwd_data_q <= port.wb_data;
         end
         if (state == READ) begin
            op_a_q     <= fwd_a_q ? fwd_data_q : port.rf_data_a;
            op_b_q     <= fwd_b_q ? fwd_data_q : port.rf_data_b;
            op_valid_q <= 1'b1;
         end else if (op_hs) begin
            op_valid_q <= 1'b0;
         end
      end
   end

`ifdef RF_SCOREBOARD_EN
   logic [NREGS-1:0] pending, pending_nx;
   logic             haz_a, haz_b;

   always_comb begin
      pending_nx = pending;
      if (port.wb_valid) pending_nx[port.wb_reg] = 1'b0;
      if (op_hs && !NOWR_MASK[opcode_q] && !illegal_q) pending_nx[rd_q] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) pending <= '0;
      else     pending <= pending_nx;
   end

   // A writeback landing in the same cycle clears the hazard; the value is forwarded at issue
   assign haz_a = pending[f_ra[IW-1:0]] && !(port.wb_valid && port.wb_reg == f_ra[IW-1:0]);
   assign haz_b = pending[f_rb[IW-1:0]] && !(port.wb_valid && port.wb_reg == f_rb[IW-1:0]);
   assign stall = haz_a || haz_b;
`else
   logic unused_cfg;
   assign unused_cfg = ^NOWR_MASK;
   assign stall      = 1'b0;
`endif

   assign port.ins_ready  = ins_ready_c;
   assign port.op_valid   = op_valid_q;
   assign port.op_opcode  = opcode_q;
   assign port.op_rd      = rd_q;
   assign port.op_a       = op_a_q;
   assign port.op_b       = op_b_q;
   assign port.op_illegal = illegal_q;
   assign port.rf_en      = issue | port.wb_valid;
   assign port.rf_we      = port.wb_valid;
   assign port.rf_sel_a   = issue ? 4'(f_ra[IW-1:0]) : sel_a_q;
   assign port.rf_sel_b   = issue ? 4'(f_rb[IW-1:0]) : sel_b_q;
   assign port.rf_sel_d   = port.wb_valid ? 4'(port.wb_reg) : 4'h0;
   assign port.rf_data_d  = port.wb_valid ? port.wb_data : '0;
endmodule
